// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with stall/flush/bubble control, a HI/LO write path,
// multi-cycle accumulate feedback to EX, and a saturating bubble counter.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned PERF_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_ex,
    input  logic                stall_mem,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [PERF_W-1:0]   bubble_cnt
);

    typedef enum logic [1:0] {
        ActHold,
        ActFlush,
        ActBubble,
        ActAdvance
    } action_e;

    action_e w_act;

    logic [ADDR_W-1:0]   r_wd,         w_wd_d;
    logic                r_wreg,       w_wreg_d;
    logic [DATA_W-1:0]   r_wdata,      w_wdata_d;
    logic                r_whilo,      w_whilo_d;
    logic [DATA_W-1:0]   r_hi,         w_hi_d;
    logic [DATA_W-1:0]   r_lo,         w_lo_d;
    logic [2*DATA_W-1:0] r_hilo,       w_hilo_d;
    logic [CNT_W-1:0]    r_cnt,        w_cnt_d;
    logic [PERF_W-1:0]   r_bubble_cnt, w_bubble_cnt_d;
    logic                w_bubble_sat;

    // stall_mem without stall_ex is illegal from ctrl; it falls through to advance.
    always_comb begin
        if (flush) begin
            w_act = ActFlush;
        end else if (stall_ex && !stall_mem) begin
            w_act = ActBubble;
        end else if (!stall_ex) begin
            w_act = ActAdvance;
        end else begin
            w_act = ActHold;
        end
    end

    assign w_bubble_sat = &r_bubble_cnt;

    always_comb begin
        w_wd_d         = r_wd;
        w_wreg_d       = r_wreg;
        w_wdata_d      = r_wdata;
        w_whilo_d      = r_whilo;
        w_hi_d         = r_hi;
        w_lo_d         = r_lo;
        w_hilo_d       = r_hilo;
        w_cnt_d        = r_cnt;
        w_bubble_cnt_d = r_bubble_cnt;
        unique case (w_act)
            ActFlush: begin
                w_wd_d    = '0;
                w_wreg_d  = 1'b0;
                w_wdata_d = '0;
                w_whilo_d = 1'b0;
                w_hi_d    = '0;
                w_lo_d    = '0;
                w_hilo_d  = '0;
                w_cnt_d   = '0;
            end
            ActBubble: begin
                w_wd_d    = '0;
                w_wreg_d  = 1'b0;
                w_wdata_d = '0;
                w_whilo_d = 1'b0;
                w_hi_d    = '0;
                w_lo_d    = '0;
                w_hilo_d  = hilo_i;
                w_cnt_d   = cnt_i;
                if (!w_bubble_sat) begin
                    w_bubble_cnt_d = r_bubble_cnt + PERF_W'(1);
                end
            end
            ActAdvance: begin
                w_wd_d    = ex_wd;
                w_wreg_d  = ex_wreg;
                w_wdata_d = ex_wdata;
                w_whilo_d = ex_whilo;
                w_hi_d    = ex_hi;
                w_lo_d    = ex_lo;
                w_hilo_d  = '0;
                w_cnt_d   = '0;
            end
            ActHold: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd         <= '0;
            r_wreg       <= 1'b0;
            r_wdata      <= '0;
            r_whilo      <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_hilo       <= '0;
            r_cnt        <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_wd         <= w_wd_d;
            r_wreg       <= w_wreg_d;
            r_wdata      <= w_wdata_d;
            r_whilo      <= w_whilo_d;
            r_hi         <= w_hi_d;
            r_lo         <= w_lo_d;
            r_hilo       <= w_hilo_d;
            r_cnt        <= w_cnt_d;
            r_bubble_cnt <= w_bubble_cnt_d;
        end
    end

    assign mem_wd     = r_wd;
    assign mem_wreg   = r_wreg;
    assign mem_wdata  = r_wdata;
    assign mem_whilo  = r_whilo;
    assign mem_hi     = r_hi;
    assign mem_lo     = r_lo;
    assign hilo_o     = r_hilo;
    assign cnt_o      = r_cnt;
    assign bubble_cnt = r_bubble_cnt;

    a_no_mem_only_stall: assert property (@(posedge clk) disable iff (rst)
        !(stall_mem && !stall_ex))
        else $error("ex_mem_stage: stall_mem asserted without stall_ex");

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; a second instance with PERF_W=4 covers saturation.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall_ex, stall_mem, flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whilo;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;

    logic [4:0]  mem_wd, s_mem_wd;
    logic        mem_wreg, mem_whilo, s_mem_wreg, s_mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo, s_mem_wdata, s_mem_hi, s_mem_lo;
    logic [63:0] hilo_o, s_hilo_o;
    logic [1:0]  cnt_o, s_cnt_o;
    logic [15:0] bubble_cnt;
    logic [3:0]  s_bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .hilo_o(hilo_o), .cnt_o(cnt_o),
        .bubble_cnt(bubble_cnt)
    );

    ex_mem_stage #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(s_mem_wd), .mem_wreg(s_mem_wreg), .mem_wdata(s_mem_wdata),
        .mem_whilo(s_mem_whilo), .mem_hi(s_mem_hi), .mem_lo(s_mem_lo), .hilo_o(s_hilo_o),
        .cnt_o(s_cnt_o), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input string tag, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic whilo,
                           input logic [31:0] hi, input logic [31:0] lo,
                           input logic [63:0] hilo, input logic [1:0] cnt,
                           input logic [15:0] bcnt);
        chk({tag, ".wd"}, 64'(mem_wd), 64'(wd));
        chk({tag, ".wreg"}, 64'(mem_wreg), 64'(wreg));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(wdata));
        chk({tag, ".whilo"}, 64'(mem_whilo), 64'(whilo));
        chk({tag, ".hi"}, 64'(mem_hi), 64'(hi));
        chk({tag, ".lo"}, 64'(mem_lo), 64'(lo));
        chk({tag, ".hilo_o"}, hilo_o, hilo);
        chk({tag, ".cnt_o"}, 64'(cnt_o), 64'(cnt));
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(bcnt));
    endtask

    initial begin
        // Reset with busy inputs
        rst = 1'b1; stall_ex = 1'b0; stall_mem = 1'b0; flush = 1'b0;
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h5555_AAAA; ex_whilo = 1'b1;
        ex_hi = 32'h1; ex_lo = 32'h2; hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'd3;
        step(); step();
        chk_mem("reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0);
        chk("reset.sat_bubble", 64'(s_bubble_cnt), 64'd0);

        // Advance: one-cycle latency
        rst = 1'b0; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
        ex_whilo = 1'b0; ex_hi = 32'h0; ex_lo = 32'h0;
        step();
        chk_mem("adv1", 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0);

        // Two bubbles with feedback
        stall_ex = 1'b1; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        step();
        chk_mem("bub1", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                64'h0000_0001_0000_0002, 2'd1, 16'd1);
        cnt_i = 2'd2;
        step();
        chk_mem("bub2", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                64'h0000_0001_0000_0002, 2'd2, 16'd2);

        // Release stall
        stall_ex = 1'b0; ex_wd = 5'd7; ex_wdata = 32'h1111_2222;
        step();
        chk_mem("release", 5'd7, 1'b1, 32'h1111_2222, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd2);

        // Hold: load, then stall both stages while inputs move
        ex_wd = 5'd9; ex_wdata = 32'h1234_5678;
        step();
        chk("hold.load", 64'(mem_wdata), 64'h1234_5678);
        stall_ex = 1'b1; stall_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_wd = 5'(i + 20); ex_wdata = 32'hF000_0000 + 32'(i); ex_wreg = 1'b0;
            hilo_i = 64'h7777_0000_0000_0000 + 64'(i); cnt_i = 2'd3; ex_whilo = 1'b1;
            step();
            chk_mem("hold", 5'd9, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd2);
        end

        // Bubble to load feedback state, then flush over a bubble request
        stall_mem = 1'b0; ex_whilo = 1'b0; ex_wreg = 1'b1;
        hilo_i = 64'hAAAA_BBBB_CCCC_DDDD; cnt_i = 2'd3;
        step();
        chk_mem("bub3", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                64'hAAAA_BBBB_CCCC_DDDD, 2'd3, 16'd3);
        ex_wd = 5'd4; ex_wdata = 32'hCAFE_F00D; ex_whilo = 1'b1;
        ex_hi = 32'h3; ex_lo = 32'h4; hilo_i = 64'h1; cnt_i = 2'd1; flush = 1'b1;
        step();
        chk_mem("flush", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd3);

        // HI/LO path
        flush = 1'b0; stall_ex = 1'b0; ex_wd = 5'd1; ex_wreg = 1'b0; ex_wdata = 32'h0;
        ex_whilo = 1'b1; ex_hi = 32'hAAAA_0000; ex_lo = 32'h0000_BBBB;
        step();
        chk_mem("hilo1", 5'd1, 1'b0, 32'h0, 1'b1, 32'hAAAA_0000, 32'h0000_BBBB,
                64'h0, 2'd0, 16'd3);
        ex_whilo = 1'b0;
        step();
        chk("hilo2.whilo", 64'(mem_whilo), 64'd0);

        // Saturation: 20 bubbles, narrow counter stops at 15
        stall_ex = 1'b1; hilo_i = 64'h0; cnt_i = 2'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("sat.narrow", 64'(s_bubble_cnt), (i + 4 > 15) ? 64'd15 : 64'(i + 4));
        end
        chk("sat.wide", 64'(bubble_cnt), 64'd23);

        // Reset in the middle of a bubble stream clears feedback and counter
        hilo_i = 64'h55; cnt_i = 2'd2;
        step();
        chk("pre_rst.cnt_o", 64'(cnt_o), 64'd2);
        rst = 1'b1;
        step();
        chk_mem("rst_mid", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 16'd0);
        chk("rst_mid.sat_bubble", 64'(s_bubble_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
